// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: opcodes, immediate extraction, queue entry.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One decoupling-queue slot: fetched word plus its PC and prediction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            taken;
    logic [XLEN-1:0] pred_pc;
  } q_entry_t;

  // Sign-extended J-type offset.
  function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Sign-extended B-type offset.
  function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  q_entry_t                 wdata,
  output q_entry_t                 head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  q_entry_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only meaningful while count is nonzero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generation with static prediction feeding a decoupling queue to the decoder.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter bit          PREDICT_EN  = 1'b1,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  output logic                          icache_req,
  output logic [31:0]                   icache_pc,
  input  logic                          icache_valid,
  input  logic [31:0]                   icache_data,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [31:0]                   dec_inst,
  output logic [31:0]                   dec_pc,
  output logic                          dec_pred_taken,
  output logic [31:0]                   dec_pred_pc,
  input  logic                          dec_redirect,
  input  logic [31:0]                   dec_redirect_pc,
  input  logic                          rob_flush,
  input  logic [31:0]                   rob_flush_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            wait_ctrl;
  logic [CW-1:0]   count;
  q_entry_t        head;
  q_entry_t        push_entry;
  logic            accept;
  logic            push;
  logic            pop;
  logic            q_flush;
  logic [6:0]      opcode;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            stall;

  assign icache_req = !wait_ctrl && (count < CW'(QUEUE_DEPTH));
  assign icache_pc  = fetch_pc;

  // A zero word means the icache has nothing for us this cycle.
  assign accept  = icache_req && icache_valid && (icache_data != '0);
  assign push    = rdy_in && accept && !rob_flush;
  assign pop     = rdy_in && dec_valid && dec_ready && !rob_flush;
  assign q_flush = rdy_in && rob_flush;

  // Predecode the returned word into a predicted next PC and a stall decision.
  always_comb begin
    opcode     = icache_data[6:0];
    seq_pc     = fetch_pc + 32'd4;
    pred_pc    = seq_pc;
    pred_taken = 1'b0;
    stall      = 1'b0;
    case (opcode)
      OP_JAL: begin
        if (PREDICT_EN) begin
          pred_taken = 1'b1;
          pred_pc    = fetch_pc + imm_j(icache_data);
        end else begin
          stall = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (PREDICT_EN) begin
          if (icache_data[31]) begin
            pred_taken = 1'b1;
            pred_pc    = fetch_pc + imm_b(icache_data);
          end
        end else begin
          stall = 1'b1;
        end
      end
      OP_JALR: stall = 1'b1;
      default: ;
    endcase
  end

  assign push_entry = '{pc: fetch_pc, inst: icache_data, taken: pred_taken, pred_pc: pred_pc};

  // Fetch PC and control-stall flag: flush > redirect > predicted next PC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc  <= RESET_PC;
      wait_ctrl <= 1'b0;
    end else if (rdy_in) begin
      if (rob_flush) begin
        fetch_pc  <= rob_flush_pc;
        wait_ctrl <= 1'b0;
      end else if (wait_ctrl && dec_redirect) begin
        fetch_pc  <= dec_redirect_pc;
        wait_ctrl <= 1'b0;
      end else if (push) begin
        fetch_pc  <= pred_pc;
        wait_ctrl <= stall;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (push),
    .pop   (pop),
    .flush (q_flush),
    .wdata (push_entry),
    .head  (head),
    .count (count)
  );

  // Decoder view of the queue head, zeroed while empty.
  assign dec_valid      = (count != '0);
  assign dec_inst       = dec_valid ? head.inst    : '0;
  assign dec_pc         = dec_valid ? head.pc      : '0;
  assign dec_pred_taken = dec_valid ? head.taken   : 1'b0;
  assign dec_pred_pc    = dec_valid ? head.pred_pc : '0;
  assign queue_count    = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: icache model driven from a small instruction map.
module tb_fetch_queue_unit;

  localparam logic [31:0] ADDI   = 32'h0010_8093;
  localparam logic [31:0] JAL20  = 32'h0200_006F;  // jal x0, +0x20
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] BEQ_P8 = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] JALR0  = 32'h0000_8067;  // jalr x0,0(x1)

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] pred_pc;
  } exp_entry_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        icache_req;
  logic [31:0] icache_pc;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic [31:0] dec_pred_pc;
  logic        dec_redirect;
  logic [31:0] dec_redirect_pc;
  logic        rob_flush;
  logic [31:0] rob_flush_pc;
  logic [3:0]  queue_count;

  int          checks = 0;
  int          errors = 0;
  int          budget = 0;
  exp_entry_t  exp_q[$];

  fetch_queue_unit #(
    .QUEUE_DEPTH (8),
    .PREDICT_EN  (1'b1),
    .RESET_PC    (32'h100)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .icache_req      (icache_req),
    .icache_pc       (icache_pc),
    .icache_valid    (icache_valid),
    .icache_data     (icache_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .dec_pred_taken  (dec_pred_taken),
    .dec_pred_pc     (dec_pred_pc),
    .dec_redirect    (dec_redirect),
    .dec_redirect_pc (dec_redirect_pc),
    .rob_flush       (rob_flush),
    .rob_flush_pc    (rob_flush_pc),
    .queue_count     (queue_count)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] pc);
    case (pc)
      32'h200: return JAL20;
      32'h300: return BEQ_M8;
      32'h400: return JALR0;
      32'h500: return BEQ_P8;
      default: return ADDI;
    endcase
  endfunction

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst,
                          input logic taken, input logic [31:0] pred);
    exp_entry_t e;
    e.pc = pc; e.inst = inst; e.taken = taken; e.pred_pc = pred;
    exp_q.push_back(e);
  endtask

  task automatic set_budget(input int n);
    budget       = n;
    icache_valid = (budget > 0);
    icache_data  = imem(icache_pc);
  endtask

  // One clock: score any pop happening at this edge, then refresh icache response.
  task automatic tick();
    logic       acc;
    logic       popping;
    exp_entry_t e;
    acc     = rst_n_in && rdy_in && !rob_flush && icache_req && icache_valid;
    popping = rst_n_in && rdy_in && !rob_flush && dec_valid && dec_ready;
    if (popping) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", dec_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", dec_pc, e.pc);
        check("pop_inst", dec_inst, e.inst);
        check("pop_taken", 32'(dec_pred_taken), 32'(e.taken));
        check("pop_pred_pc", dec_pred_pc, e.pred_pc);
      end
    end
    @(posedge clk_in);
    #1;
    if (acc && budget > 0) budget--;
    rob_flush    = 1'b0;
    dec_redirect = 1'b0;
    icache_valid = (budget > 0);
    icache_data  = imem(icache_pc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic flush_to(input logic [31:0] pc);
    set_budget(0);
    rob_flush    = 1'b1;
    rob_flush_pc = pc;
    tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(queue_count), 32'd0);
  endtask

  initial begin
    rst_n_in        = 1'b0;
    rdy_in          = 1'b1;
    icache_valid    = 1'b0;
    icache_data     = '0;
    dec_ready       = 1'b0;
    dec_redirect    = 1'b0;
    dec_redirect_pc = '0;
    rob_flush       = 1'b0;
    rob_flush_pc    = '0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_icache_pc", icache_pc, 32'h100);
    check("rst_dec_inst", dec_inst, 32'd0);
    rst_n_in = 1'b1;

    // Sequential fetch from reset PC
    dec_ready = 1'b1;
    exp_push(32'h100, ADDI, 1'b0, 32'h104);
    exp_push(32'h104, ADDI, 1'b0, 32'h108);
    exp_push(32'h108, ADDI, 1'b0, 32'h10C);
    set_budget(3);
    drain(20);
    check("seq_icache_pc", icache_pc, 32'h10C);

    // Fill to capacity, then one pop reopens a slot
    flush_to(32'h1000);
    dec_ready = 1'b0;
    set_budget(100);
    ticks(12);
    check("full_count", 32'(queue_count), 32'd8);
    check("full_req", 32'(icache_req), 32'd0);
    dec_ready = 1'b1;
    exp_push(32'h1000, ADDI, 1'b0, 32'h1004);
    tick();
    dec_ready = 1'b0;
    check("after_pop_count", 32'(queue_count), 32'd7);
    check("after_pop_req", 32'(icache_req), 32'd1);
    tick();
    check("refill_count", 32'(queue_count), 32'd8);
    check("refill_req", 32'(icache_req), 32'd0);
    flush_to(32'h0);
    check("flush_empty", 32'(queue_count), 32'd0);

    // JAL predicted taken
    flush_to(32'h200);
    check("jal_start_pc", icache_pc, 32'h200);
    dec_ready = 1'b1;
    exp_push(32'h200, JAL20, 1'b1, 32'h220);
    exp_push(32'h220, ADDI, 1'b0, 32'h224);
    set_budget(2);
    tick();
    check("jal_next_pc", icache_pc, 32'h220);
    drain(20);

    // Backward branch taken
    flush_to(32'h300);
    exp_push(32'h300, BEQ_M8, 1'b1, 32'h2F8);
    exp_push(32'h2F8, ADDI, 1'b0, 32'h2FC);
    set_budget(2);
    tick();
    check("beq_back_next_pc", icache_pc, 32'h2F8);
    drain(20);

    // Forward branch not taken
    flush_to(32'h500);
    exp_push(32'h500, BEQ_P8, 1'b0, 32'h504);
    exp_push(32'h504, ADDI, 1'b0, 32'h508);
    set_budget(2);
    tick();
    check("beq_fwd_next_pc", icache_pc, 32'h504);
    drain(20);

    // JALR stalls until decoder redirect; older entries survive
    flush_to(32'h3F8);
    dec_ready = 1'b0;
    exp_push(32'h3F8, ADDI, 1'b0, 32'h3FC);
    exp_push(32'h3FC, ADDI, 1'b0, 32'h400);
    exp_push(32'h400, JALR0, 1'b0, 32'h404);
    set_budget(3);
    ticks(5);
    check("jalr_req", 32'(icache_req), 32'd0);
    check("jalr_count", 32'(queue_count), 32'd3);
    dec_redirect    = 1'b1;
    dec_redirect_pc = 32'h800;
    tick();
    check("redirect_pc", icache_pc, 32'h800);
    check("redirect_count", 32'(queue_count), 32'd3);
    check("redirect_req", 32'(icache_req), 32'd1);
    exp_push(32'h800, ADDI, 1'b0, 32'h804);
    set_budget(1);
    dec_ready = 1'b1;
    drain(20);
    dec_redirect    = 1'b1;
    dec_redirect_pc = 32'h900;
    tick();
    check("redirect_ignored", icache_pc, 32'h804);

    // rdy_in low freezes everything
    flush_to(32'h600);
    dec_ready = 1'b0;
    set_budget(2);
    ticks(3);
    rdy_in    = 1'b0;
    dec_ready = 1'b1;
    set_budget(5);
    ticks(3);
    check("pause_count", 32'(queue_count), 32'd2);
    check("pause_pc", icache_pc, 32'h608);
    rdy_in = 1'b1;
    set_budget(0);
    exp_push(32'h600, ADDI, 1'b0, 32'h604);
    exp_push(32'h604, ADDI, 1'b0, 32'h608);
    drain(20);

    // Flush beats redirect, pop and a same-cycle icache response
    flush_to(32'h1000);
    dec_ready = 1'b0;
    set_budget(5);
    ticks(7);
    check("preflush_count", 32'(queue_count), 32'd5);
    set_budget(1);
    rob_flush       = 1'b1;
    rob_flush_pc    = 32'h40;
    dec_redirect    = 1'b1;
    dec_redirect_pc = 32'h900;
    dec_ready       = 1'b1;
    tick();
    check("flush_count", 32'(queue_count), 32'd0);
    check("flush_dec_valid", 32'(dec_valid), 32'd0);
    check("flush_pc", icache_pc, 32'h40);
    check("flush_req", 32'(icache_req), 32'd1);
    exp_push(32'h40, ADDI, 1'b0, 32'h44);
    drain(20);

    // Mid-operation reset discards the queue
    flush_to(32'h700);
    dec_ready = 1'b0;
    set_budget(3);
    ticks(5);
    rst_n_in = 1'b0;
    #2;
    check("mrst_count", 32'(queue_count), 32'd0);
    check("mrst_dec_valid", 32'(dec_valid), 32'd0);
    check("mrst_pc", icache_pc, 32'h100);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    set_budget(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
